// File: rtl/pfa_ntt_sequencer_if.sv
// Handshake/control bundle between a PFA-NTT job controller and the sequencer.
// master drives job requests and stall; slave (the sequencer) drives memory/butterfly controls.
interface pfa_ntt_sequencer_if #(
   parameter int W_IDX_W = 11
);
   logic               start;
   logic [1:0]         mode;
   logic [5:0]         mod_idx;
   logic               stall;
   logic [1:0]         stage;
   logic [8:0]         row;
   logic [2:0]         step;
   logic [2:0]         phase;
   logic               we;
   logic               bfa_mode;
   logic               bfa_swap;
   logic [W_IDX_W-1:0] w_idx;
   logic               busy;
   logic               done;

   modport master (
      output start, mode, mod_idx, stall,
      input  stage, row, step, phase, we, bfa_mode, bfa_swap, w_idx, busy, done
   );

   modport slave (
      input  start, mode, mod_idx, stall,
      output stage, row, step, phase, we, bfa_mode, bfa_swap, w_idx, busy, done
   );
endinterface

// File: rtl/pfa_ntt_sequencer.sv
// Multi-stage PFA/NTT address and twiddle sequencer: walks rows and passes of each stage
// through PERM, NTT, pointwise multiply, INTT and DRAIN, emitting write and butterfly controls.
module pfa_ntt_sequencer #(
   parameter int NUM_STAGES     = 3,
   parameter int ROWS_0         = 85,
   parameter int ROWS_1         = 256,
   parameter int ROWS_2         = 256,
   parameter int ROWS_3         = 256,
   parameter int STEPS_0        = 8,
   parameter int STEPS_1        = 4,
   parameter int STEPS_2        = 2,
   parameter int STEPS_3        = 1,
   parameter int ROW_STRIDE     = 3,
   parameter int PIPELINE_DELAY = 1,
   parameter int W_STRIDE       = 34,
   parameter int W_IDX_W        = 11
) (
   input logic                  clk,
   input logic                  reset,
   pfa_ntt_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PERM  = 3'd1,
      NTT   = 3'd2,
      MUL_B = 3'd3,
      MUL_A = 3'd4,
      INTT  = 3'd5,
      DRAIN = 3'd6
   } state_t;

   localparam logic [W_IDX_W-1:0] W_ONE = W_IDX_W'(1);
   localparam bit CFG_OK =
      (NUM_STAGES < 2 || ((ROWS_1 - 1) % ROW_STRIDE) == 0) &&
      (NUM_STAGES < 3 || ((ROWS_2 - 1) % ROW_STRIDE) == 0) &&
      (NUM_STAGES < 4 || ((ROWS_3 - 1) % ROW_STRIDE) == 0);

   state_t             state_q, state_d;
   logic [2:0]         stage_q, stage_d;
   logic [8:0]         row_q, row_d;
   logic [2:0]         step_q, step_d;
   logic [W_IDX_W-1:0] w_q, w_d;
   logic [1:0]         mode_q, mode_d;
   logic [4:0]         drain_q, drain_d;

   function automatic logic [8:0] last_row_of(input logic [2:0] s);
      case (s)
         3'd0:    return 9'(ROWS_0 - 1);
         3'd1:    return 9'(ROWS_1 - 1);
         3'd2:    return 9'(ROWS_2 - 1);
         default: return 9'(ROWS_3 - 1);
      endcase
   endfunction

   function automatic logic [2:0] last_step_of(input logic [2:0] s);
      case (s)
         3'd0:    return 3'(STEPS_0 - 1);
         3'd1:    return 3'(STEPS_1 - 1);
         3'd2:    return 3'(STEPS_2 - 1);
         default: return 3'(STEPS_3 - 1);
      endcase
   endfunction

   logic       last_row, last_step, drain_final, job_end;
   logic [8:0] row_inc, row_adv;
   logic [2:0] stage_eff;
   state_t     restart_state;

   always_comb begin
      last_row      = (row_q == last_row_of(stage_q));
      last_step     = (step_q == last_step_of(stage_q));
      row_inc       = (stage_q == 3'd0) ? 9'd1 : 9'(ROW_STRIDE);
      row_adv       = last_row ? 9'd0 : row_q + row_inc;
      // stage is bumped on the first DRAIN cycle, so later cycles already hold the new value
      stage_eff     = (drain_q == 5'd0) ? stage_q + 3'd1 : stage_q;
      drain_final   = (drain_q == 5'(PIPELINE_DELAY - 1));
      job_end       = drain_final && (stage_eff == 3'(NUM_STAGES));
      restart_state = (mode_q == 2'd2) ? INTT : PERM;
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      row_d   = row_q;
      step_d  = step_q;
      w_d     = w_q;
      mode_d  = mode_q;
      drain_d = drain_q;
      if (state_q == IDLE) begin
         if (bus.start) begin
            mode_d  = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
            w_d     = W_IDX_W'(32'(bus.mod_idx) * W_STRIDE);
            stage_d = 3'd0;
            row_d   = 9'd0;
            step_d  = 3'd0;
            drain_d = 5'd0;
            state_d = (bus.mode == 2'd2) ? INTT : PERM;
         end
      end else if (!bus.stall) begin
         case (state_q)
            PERM: begin
               row_d = row_adv;
               if (last_row) begin
                  step_d  = 3'd0;
                  state_d = NTT;
               end
            end
            NTT: begin
               row_d = row_adv;
               if (last_row) begin
                  w_d = w_q + W_ONE;
                  if (last_step) state_d = (mode_q == 2'd0) ? MUL_B : DRAIN;
                  else           step_d  = step_q + 3'd1;
               end
            end
            MUL_B: begin
               w_d     = w_q + W_ONE;
               state_d = MUL_A;
            end
            MUL_A: begin
               if (last_row) begin
                  w_d     = w_q + W_ONE;
                  row_d   = 9'd0;
                  step_d  = 3'd0;
                  state_d = INTT;
               end else begin
                  w_d     = w_q - W_ONE;
                  row_d   = row_adv;
                  state_d = MUL_B;
               end
            end
            INTT: begin
               row_d = row_adv;
               if (last_row) begin
                  if (last_step) begin
                     state_d = DRAIN;
                  end else begin
                     step_d = step_q + 3'd1;
                     w_d    = w_q + W_ONE;
                  end
               end
            end
            DRAIN: begin
               if (drain_q == 5'd0) begin
                  stage_d = stage_q + 3'd1;
                  w_d     = w_q + W_ONE;
               end
               if (drain_final) begin
                  drain_d = 5'd0;
                  row_d   = 9'd0;
                  step_d  = 3'd0;
                  if (job_end) begin
                     stage_d = 3'd0;
                     state_d = IDLE;
                  end else begin
                     stage_d = stage_eff;
                     state_d = restart_state;
                  end
               end else begin
                  drain_d = drain_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         stage_q <= 3'd0;
         row_q   <= 9'd0;
         step_q  <= 3'd0;
         w_q     <= '0;
         mode_q  <= 2'd0;
         drain_q <= 5'd0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         row_q   <= row_d;
         step_q  <= step_d;
         w_q     <= w_d;
         mode_q  <= mode_d;
         drain_q <= drain_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (CFG_OK);
   end

   assign bus.phase    = state_q;
   assign bus.stage    = stage_q[1:0];
   assign bus.row      = row_q;
   assign bus.step     = step_q;
   assign bus.w_idx    = w_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.we       = !bus.stall && (state_q == PERM || state_q == NTT ||
                                        state_q == MUL_A || state_q == INTT);
   assign bus.bfa_mode = (state_q == MUL_B) || (state_q == MUL_A);
   assign bus.bfa_swap = (state_q == MUL_A);
   assign bus.done     = !bus.stall && (state_q == DRAIN) && job_end;

endmodule

// File: tb/tb_pfa_ntt_sequencer.sv
// Randomized bench for pfa_ntt_sequencer: a loop-based job model expands each job into its
// expected per-cycle trace, which is compared against the DUT under stalls, noise and resets.
module tb_pfa_ntt_sequencer;
   localparam int NS = 2, R0 = 4, R1 = 7, S0 = 2, S1 = 1, RS = 3, PD = 3, WS = 34, WW = 11;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pfa_ntt_sequencer_if #(.W_IDX_W(WW)) bus();

   pfa_ntt_sequencer #(
      .NUM_STAGES(NS), .ROWS_0(R0), .ROWS_1(R1), .STEPS_0(S0), .STEPS_1(S1),
      .ROW_STRIDE(RS), .PIPELINE_DELAY(PD), .W_STRIDE(WS), .W_IDX_W(WW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {int st; int stg; int row; int step; int w;} ent_t;
   ent_t exp_q[$];
   int   w_end;
   int   n_chk = 0, n_err = 0;
   int   busy_n, we_n, done_n, bm_n, first_w;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack(int st, int stg, int row, int step, int w,
                                        bit we, bit bm, bit bs, bit busy, bit done);
      return {31'd0, 3'(st), 2'(stg), 9'(row), 3'(step), 11'(w), we, bm, bs, busy, done};
   endfunction

   function automatic logic [63:0] obs_vec();
      return {31'd0, bus.phase, bus.stage, bus.row, bus.step, bus.w_idx,
              bus.we, bus.bfa_mode, bus.bfa_swap, bus.busy, bus.done};
   endfunction

   task automatic push(input int st, input int stg, input int row, input int step, input int w);
      ent_t e;
      e = '{st, stg, row, step, w};
      exp_q.push_back(e);
   endtask

   // Expected trace of one job: 1=PERM 2=NTT 3=MUL_B 4=MUL_A 5=INTT 6=DRAIN
   task automatic build_job(input int mode, input int mi);
      int m, w, inc, nr;
      int rows[2];
      int steps[2];
      rows  = '{R0, R1};
      steps = '{S0, S1};
      m = (mode == 3) ? 0 : mode;
      w = (mi * WS) % 2048;
      exp_q.delete();
      for (int s = 0; s < NS; s++) begin
         inc = (s == 0) ? 1 : RS;
         nr  = (rows[s] - 1) / inc + 1;
         if (m != 2) begin
            for (int i = 0; i < nr; i++) push(1, s, i * inc, 0, w);
            for (int p = 0; p < steps[s]; p++) begin
               for (int i = 0; i < nr; i++) push(2, s, i * inc, p, w);
               w = (w + 1) % 2048;
            end
            if (m == 0) begin
               for (int i = 0; i < nr; i++) begin
                  push(3, s, i * inc, steps[s] - 1, w);
                  w = (w + 1) % 2048;
                  push(4, s, i * inc, steps[s] - 1, w);
                  w = (i == nr - 1) ? (w + 1) % 2048 : (w + 2047) % 2048;
               end
            end
         end
         if (m != 1) begin
            for (int p = 0; p < steps[s]; p++) begin
               for (int i = 0; i < nr; i++) push(5, s, i * inc, p, w);
               if (p < steps[s] - 1) w = (w + 1) % 2048;
            end
         end
         push(6, s, 0, steps[s] - 1, w);
         w = (w + 1) % 2048;
         for (int d = 1; d < PD; d++) push(6, (s + 1) % 4, 0, steps[s] - 1, w);
      end
      w_end = w;
   endtask

   function automatic int count_we();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].st inside {1, 2, 4, 5}) n++;
      return n;
   endfunction

   task automatic run_job(input int mode, input int mi, input bit noise, input bit start_stall,
                          input int stall_at, input int stall_len, input int stall_pct,
                          input bit abort);
      int   idx = 0, guard = 0, sleft = stall_len, abort_idx = -1;
      bit   stl, lst, ewe;
      ent_t e;
      build_job(mode, mi);
      if (abort)
         foreach (exp_q[i]) if (abort_idx < 0 && exp_q[i].st == 4 && exp_q[i].stg == 1) abort_idx = i;
      busy_n = 0; we_n = 0; done_n = 0; bm_n = 0; first_w = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 2'(mode); bus.mod_idx = 6'(mi); bus.stall = start_stall;
      @(negedge clk);
      bus.start = 1'b0;
      while (idx < exp_q.size() && guard < 4000) begin
         guard++;
         stl = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
         if (stall_at >= 0 && idx >= stall_at && sleft > 0) begin
            stl = 1'b1;
            sleft--;
         end
         if (abort) stl = 1'b0;
         bus.stall = stl;
         if (noise) begin
            bus.start   = ($urandom_range(2) == 0);
            bus.mode    = 2'($urandom_range(3));
            bus.mod_idx = 6'($urandom_range(63));
         end
         #1;
         e   = exp_q[idx];
         lst = (idx == exp_q.size() - 1);
         ewe = !stl && (e.st inside {1, 2, 4, 5});
         chk("trace", obs_vec(), pack(e.st, e.stg, e.row, e.step, e.w, ewe,
                                      e.st == 3 || e.st == 4, e.st == 4, 1'b1, lst && !stl));
         if (first_w < 0) first_w = int'(bus.w_idx);
         busy_n += int'(bus.busy); we_n += int'(bus.we);
         done_n += int'(bus.done); bm_n += int'(bus.bfa_mode);
         if (idx == abort_idx) begin
            reset = 1'b1; bus.stall = 1'b1; bus.start = 1'b1;
            @(negedge clk);
            #1;
            chk("reset_mid", obs_vec(), 64'd0);
            reset = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
            return;
         end
         if (!stl) idx++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      chk("job_len", idx, exp_q.size());
      #1;
      chk("idle", obs_vec(), pack(0, 0, 0, 0, w_end, 0, 0, 0, 0, 0));
   endtask

   initial begin
      bus.start = 1'b0; bus.mode = 2'd0; bus.mod_idx = 6'd0; bus.stall = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_state", obs_vec(), 64'd0);
      reset = 1'b0;

      run_job(0, 2, 0, 0, -1, 0, 0, 0);
      chk("first_w", first_w, 68);
      chk("full_busy", busy_n, 49);
      chk("full_we", we_n, count_we());
      chk("full_done", done_n, 1);

      run_job(1, 5, 0, 0, -1, 0, 0, 0);
      chk("fwd_busy", busy_n, exp_q.size());
      chk("fwd_bfa", bm_n, 0);
      chk("fwd_done", done_n, 1);

      run_job(0, 2, 0, 0, R0 + 3, 5, 0, 0);
      chk("stall_busy", busy_n, 49 + 5);
      chk("stall_we", we_n, count_we());
      chk("stall_done", done_n, 1);

      run_job(0, 7, 1, 0, -1, 0, 0, 0);
      chk("noise_done", done_n, 1);

      run_job(0, 1, 0, 0, -1, 0, 0, 1);
      run_job(0, 3, 0, 0, -1, 0, 0, 0);
      chk("after_rst_busy", busy_n, 49);
      chk("after_rst_done", done_n, 1);

      run_job(2, 62, 0, 1, -1, 0, 0, 0);
      chk("inv_done", done_n, 1);
      chk("inv_busy", busy_n, exp_q.size());

      repeat (6) begin
         run_job($urandom_range(3), $urandom_range(63), 1'($urandom_range(1)),
                 1'($urandom_range(1)), -1, 0, 20, 0);
         chk("rnd_done", done_n, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
